fetch_sequencer: RTL and testbench

- Control FSM that sequences the program_counter through fetch, issue, execute and PC-update phases.
- Drives the PC's latch, branch and immediate-address inputs.
- Issues instruction-memory reads with a req/ready handshake and hands each fetched instruction to the execute stage.
- Sits between program_counter, instruction memory and the execute unit; detects memory timeouts and misaligned branch targets.

---
 rtl/fetch_sequencer.sv | 97 +++++++++
 tb/tb_fetch_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: control FSM stepping the PC through fetch, issue, execute and update,
// with an instruction-memory timeout and misaligned-branch fault.
module fetch_sequencer #(
    parameter int PC_SIZE     = 32,
    parameter int INSTR_WIDTH = 64,
    parameter int MAX_WAIT    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   halt,
    input  logic [PC_SIZE-1:0]     pc,
    output logic                   pc_latch,
    output logic                   pc_branch,
    output logic [PC_SIZE-1:0]     pc_target,
    output logic                   imem_req,
    output logic [PC_SIZE-1:0]     imem_addr,
    input  logic                   imem_ready,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr,
    input  logic                   exec_done,
    input  logic                   exec_branch,
    input  logic [PC_SIZE-1:0]     exec_target,
    output logic                   busy,
    output logic                   fault
);
    localparam int WW = $clog2(MAX_WAIT) + 1;
    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, EXECUTE, UPDATE, FAULT} state_t;
    state_t                 state_q, state_d;
    logic [WW-1:0]          wait_q, wait_d;
    logic                   halt_q, halt_d;
    logic                   br_q, br_d;
    logic [PC_SIZE-1:0]     tgt_q, tgt_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wait_q  <= '0;
            halt_q  <= 1'b0;
            br_q    <= 1'b0;
            tgt_q   <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            halt_q  <= halt_d;
            br_q    <= br_d;
            tgt_q   <= tgt_d;
            instr_q <= instr_d;
        end
    end
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        halt_d  = halt_q | (busy & halt);
        br_d    = br_q;
        tgt_d   = tgt_q;
        instr_d = instr_q;
        case (state_q)
            IDLE: state_d = start ? FETCH : IDLE;
            FETCH: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    wait_d  = '0;
                    state_d = ISSUE;
                end else begin
                    wait_d  = wait_q + 1'b1;
                    state_d = (wait_q == WW'(MAX_WAIT - 1)) ? FAULT : FETCH;
                end
            end
            ISSUE: state_d = EXECUTE;
            EXECUTE: begin
                if (exec_done) begin
                    br_d    = exec_branch;
                    tgt_d   = exec_branch ? exec_target : '0;
                    state_d = (exec_branch && exec_target[2:0] != 3'd0) ? FAULT : UPDATE;
                end
            end
            UPDATE: begin
                state_d = halt_q ? IDLE : FETCH;
                halt_d  = halt_q ? 1'b0 : halt;
            end
            FAULT: state_d = FAULT;
            default: state_d = IDLE;
        endcase
    end
    assign busy        = (state_q != IDLE) && (state_q != FAULT);
    assign fault       = state_q == FAULT;
    assign imem_req    = state_q == FETCH;
    assign imem_addr   = imem_req ? pc : '0;
    assign instr_valid = state_q == ISSUE;
    assign instr       = fault ? '0 : instr_q;
    assign pc_latch    = state_q == UPDATE;
    assign pc_branch   = pc_latch & br_q;
    assign pc_target   = pc_branch ? tgt_q : '0;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: table-driven instruction runs with an instruction scoreboard,
// plus directed timeout, halt and async-reset sequences.
module tb_fetch_sequencer;
    logic        clk = 0, rst = 1, start = 0, halt = 0;
    logic [31:0] pc;
    logic        pc_latch, pc_branch, imem_req, imem_ready = 0, instr_valid;
    logic [31:0] pc_target, imem_addr, exec_target = 0;
    logic [63:0] imem_rdata = 0, instr;
    logic        exec_done = 0, exec_branch = 0, busy, fault;
    int          checks = 0, errors = 0;
    logic [31:0] exp_pc;
    logic [63:0] exp_q[$];

    typedef struct {
        logic [63:0] data;
        int          delay;
        logic        br;
        logic [31:0] tgt;
        logic        exp_br;
        logic [31:0] exp_tgt;
        logic        exp_fault;
    } vec_t;
    vec_t tbl[6];

    fetch_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .halt(halt), .pc(pc),
        .pc_latch(pc_latch), .pc_branch(pc_branch), .pc_target(pc_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr),
        .exec_done(exec_done), .exec_branch(exec_branch), .exec_target(exec_target),
        .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    // Stand-in for the external program_counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc <= '0;
        else if (pc_latch) pc <= pc_branch ? pc_target : pc + 32'd8;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1;
        #1;
        chk("reset_outputs", 64'(|{pc_latch, pc_branch, pc_target, imem_req, imem_addr,
                                   instr_valid, instr, busy, fault}), 0);
        step();
        rst = 0;
        exp_pc = 0;
    endtask

    task automatic do_start();
        start = 1;
        step();
        start = 0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 40) begin
            step();
            n++;
        end
        chk("fetch_reached", imem_req, 1);
    endtask

    task automatic run_rec(input vec_t v, input logic halt_in_exec);
        wait_req();
        chk("imem_addr", imem_addr, exp_pc);
        for (int i = 0; i < v.delay; i++) step();
        chk("still_fetching", imem_req, 1);
        imem_ready = 1;
        imem_rdata = v.data;
        exp_q.push_back(v.data);
        step();
        imem_ready = 1;
        imem_rdata = ~v.data;
        chk("instr_valid", instr_valid, 1);
        chk("no_latch_in_issue", pc_latch, 0);
        if (instr_valid) begin
            if (exp_q.size() == 0) chk("scoreboard_underflow", 1, 0);
            else chk("instr", instr, exp_q.pop_front());
        end
        exec_done = 1;
        exec_branch = 1;
        exec_target = 32'h17;
        step();
        imem_ready = 0;
        chk("instr_valid_pulse", instr_valid, 0);
        chk("no_req_in_exec", imem_req, 0);
        exec_done = 0;
        if (halt_in_exec) begin
            halt = 1;
            step();
            halt = 0;
            chk("exec_waits", busy, 1);
        end
        exec_done = 1;
        exec_branch = v.br;
        exec_target = v.tgt;
        step();
        exec_done = 0;
        exec_branch = 0;
        exec_target = 0;
        chk("fault", fault, v.exp_fault);
        chk("busy", busy, !v.exp_fault);
        chk("pc_latch", pc_latch, !v.exp_fault);
        chk("pc_branch", pc_branch, v.exp_br);
        chk("pc_target", pc_target, v.exp_tgt);
        if (!v.exp_fault) exp_pc = v.exp_br ? v.exp_tgt : exp_pc + 32'd8;
        step();
    endtask

    initial begin
        int n;
        vec_t h;
        tbl[0] = '{64'h1111_2222_3333_4444, 0,  1'b0, 32'h40,  1'b0, 32'h0,   1'b0};
        tbl[1] = '{64'hdead_beef_0000_0001, 2,  1'b1, 32'h18,  1'b1, 32'h18,  1'b0};
        tbl[2] = '{64'h0123_4567_89ab_cdef, 0,  1'b0, 32'h0,   1'b0, 32'h0,   1'b0};
        tbl[3] = '{64'hffff_0000_ffff_0000, 15, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0};
        tbl[4] = '{64'h5a5a_a5a5_5a5a_a5a5, 1,  1'b0, 32'h8,   1'b0, 32'h0,   1'b0};
        tbl[5] = '{64'hcafe_f00d_1234_5678, 0,  1'b1, 32'h17,  1'b0, 32'h0,   1'b1};
        do_reset();
        step();
        chk("idle_no_req", imem_req, 0);
        do_start();
        for (int i = 0; i < 6; i++) run_rec(tbl[i], 1'b0);
        for (int i = 0; i < 4; i++) begin
            start = i[0];
            step();
            chk("fault_sticky", fault, 1);
            chk("fault_no_req", imem_req, 0);
        end
        start = 0;
        do_reset();
        chk("fault_cleared", fault, 0);

        // memory timeout
        do_start();
        n = 0;
        while (imem_req && n < 40) begin
            n++;
            step();
        end
        chk("timeout_req_cycles", n, 16);
        chk("timeout_fault", fault, 1);
        chk("timeout_busy", busy, 0);

        // halt during EXECUTE completes UPDATE, then idles
        do_reset();
        do_start();
        h = '{64'h0bad_c0de_0000_0042, 0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
        run_rec(h, 1'b1);
        chk("halt_idle", busy, 0);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            n += int'(imem_req);
        end
        chk("halt_no_req", n, 0);
        halt = 1;
        step();
        halt = 0;
        chk("idle_halt_ignored", busy, 0);
        do_start();
        h.data = 64'h7777_8888_9999_aaaa;
        run_rec(h, 1'b0);
        chk("no_stale_halt", imem_req, 1);
        chk("fetch_after_halt", imem_addr, 32'h10);

        // async reset mid-EXECUTE
        do_reset();
        do_start();
        wait_req();
        imem_ready = 1;
        imem_rdata = 64'h1234;
        step();
        imem_ready = 0;
        step();
        chk("in_execute", busy, 1);
        #2;
        rst = 1;
        #1;
        chk("async_outs", 64'(|{pc_latch, pc_branch, pc_target, imem_req, imem_addr,
                                 instr_valid, busy, fault}), 0);
        chk("async_instr", instr, 0);
        step();
        rst = 0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            n += int'(imem_req | busy | instr_valid | pc_latch);
        end
        chk("post_reset_quiet", n, 0);
        chk("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
